// File: rtl/routing_pkg.sv
// Constants and state encoding shared by the 4:1 routing mux family.
// Includes the sel-to-one-hot helper used to build grant vectors.
package routing_pkg;

  localparam int SEL_W = 2;
  localparam int N_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority encoder for four requesters.
// The search starts one above 'last' and wraps; the first set bit wins.
module rr_pick4
  import routing_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_idx1;
  logic [SEL_W-1:0] w_idx2;
  logic [SEL_W-1:0] w_idx3;
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  // Two-bit adds wrap naturally, giving the mod-4 rotation for free.
  assign w_start = last + 2'd1;
  assign w_idx1  = w_start + 2'd1;
  assign w_idx2  = w_start + 2'd2;
  assign w_idx3  = w_start + 2'd3;

  assign w_rot[0] = req[w_start];
  assign w_rot[1] = req[w_idx1];
  assign w_rot[2] = req[w_idx2];
  assign w_rot[3] = req[w_idx3];

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign any = |req;
  assign win = w_start + w_off;

endmodule

// File: rtl/mux4_rr_select.sv
// Round-robin select sequencer driving the 4:1 one-bit routing mux (sel, one-hot grant, valid).
// Optional grant locking across transfers is enabled by defining MUX4_RR_LOCK_EN.
module mux4_rr_select
  import routing_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       lock,
  input  logic       ready,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_grant;
  logic             r_valid;
  logic             r_timeout;
  logic [SEL_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_sel_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;
  logic [SEL_W-1:0] w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [SEL_W-1:0] w_pick_last;
  logic             w_any;
  logic [SEL_W-1:0] w_win;
  logic             w_req_sel;
  logic             w_cnt_max;
  logic             w_lock_xfer;

  // In BUSY a transfer makes sel the new 'last', so arbitrate from sel directly;
  // this lets the back-to-back reload happen in the same edge as the transfer.
  assign w_pick_last = (r_state == ST_BUSY) ? r_sel : r_last;

  rr_pick4 u_pick (
    .req  (req),
    .last (w_pick_last),
    .any  (w_any),
    .win  (w_win)
  );

  assign w_req_sel = req[r_sel];
  assign w_cnt_max = (r_cnt == CNT_MAX);

`ifdef MUX4_RR_LOCK_EN
  assign w_lock_xfer = lock & w_req_sel;
`else
  logic w_unused_lock;
  assign w_unused_lock = lock;
  assign w_lock_xfer   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (ready) begin
          if (w_lock_xfer || w_any) w_state_nxt = ST_BUSY;
          else                      w_state_nxt = ST_IDLE;
        end else if (!w_req_sel || w_cnt_max) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Withdraw is checked before timeout so a source that leaves keeps its priority.
  always_comb begin
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_sel_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        if (ready) begin
          if (w_lock_xfer) begin
            w_cnt_nxt = '0;
          end else begin
            w_last_nxt = r_sel;
            if (w_any) begin
              w_sel_nxt   = w_win;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_valid_nxt = 1'b0;
            end
          end
        end else if (!w_req_sel) begin
          w_valid_nxt = 1'b0;
        end else if (w_cnt_max) begin
          w_timeout_nxt = 1'b1;
          w_last_nxt    = r_sel;
          w_valid_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_max ? r_cnt : r_cnt + 1'b1;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
    w_grant_nxt = w_valid_nxt ? sel_onehot(w_sel_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed bench for mux4_rr_select: vector table for arbitration sequences,
// plus a hand-written sequence for the timeout abandon path.
module tb_mux4_rr_select;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       lock;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic       ready;
    logic [1:0] e_sel;
    logic [3:0] e_grant;
    logic       e_valid;
    logic       e_tmo;
  } vec_t;

  vec_t tv[25];

  mux4_rr_select #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .ready   (ready),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic l,
                              input logic rd, input logic [1:0] es, input logic [3:0] eg,
                              input logic ev, input logic et);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.ready = rd;
    v.e_sel = es; v.e_grant = eg; v.e_valid = ev; v.e_tmo = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] es, input logic [3:0] eg,
                       input logic ev, input logic et);
    n_vec++;
    if (sel !== es || grant !== eg || valid !== ev || timeout !== et) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d grant=%b valid=%b timeout=%b, want sel=%0d grant=%b valid=%b timeout=%b",
               name, sel, grant, valid, timeout, es, eg, ev, et);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic l, input logic rd);
    reset = r; req = q; lock = l; ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1; req = '0; lock = 1'b0; ready = 1'b0;

    // full rotation with ready held high
    tv[0]  = mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 0);
    tv[1]  = mk(0, 4'b1111, 0, 1, 2'd0, 4'b0001, 1, 0);
    tv[2]  = mk(0, 4'b1111, 0, 1, 2'd1, 4'b0010, 1, 0);
    tv[3]  = mk(0, 4'b1111, 0, 1, 2'd2, 4'b0100, 1, 0);
    tv[4]  = mk(0, 4'b1111, 0, 1, 2'd3, 4'b1000, 1, 0);
    tv[5]  = mk(0, 4'b1111, 0, 1, 2'd0, 4'b0001, 1, 0);
    // single requester re-picked back-to-back
    tv[6]  = mk(0, 4'b0001, 0, 1, 2'd0, 4'b0001, 1, 0);
    tv[7]  = mk(0, 4'b0001, 0, 1, 2'd0, 4'b0001, 1, 0);
    tv[8]  = mk(0, 4'b0000, 0, 1, 2'd0, 4'b0000, 0, 0);
    // withdraw leaves last=1, so 4'b0101 then grants 2
    tv[9]  = mk(0, 4'b0010, 0, 0, 2'd1, 4'b0010, 1, 0);
    tv[10] = mk(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 1, 0);
    tv[11] = mk(0, 4'b0000, 0, 0, 2'd2, 4'b0000, 0, 0);
    tv[12] = mk(0, 4'b0101, 0, 0, 2'd2, 4'b0100, 1, 0);
    tv[13] = mk(0, 4'b0101, 0, 1, 2'd0, 4'b0001, 1, 0);
    // reset mid-transfer
    tv[14] = mk(1, 4'b1111, 0, 1, 2'd0, 4'b0000, 0, 0);
    tv[15] = mk(0, 4'b1000, 0, 0, 2'd3, 4'b1000, 1, 0);
    tv[16] = mk(0, 4'b1000, 0, 0, 2'd3, 4'b1000, 1, 0);
    tv[17] = mk(0, 4'b0000, 0, 1, 2'd3, 4'b0000, 0, 0);
    tv[18] = mk(0, 4'b0000, 0, 1, 2'd3, 4'b0000, 0, 0);
    // lock behaviour depends on build
    tv[19] = mk(0, 4'b0011, 1, 0, 2'd0, 4'b0001, 1, 0);
`ifdef MUX4_RR_LOCK_EN
    tv[20] = mk(0, 4'b0011, 1, 1, 2'd0, 4'b0001, 1, 0);
    tv[21] = mk(0, 4'b0011, 1, 1, 2'd0, 4'b0001, 1, 0);
    tv[22] = mk(0, 4'b0011, 1, 1, 2'd0, 4'b0001, 1, 0);
    tv[23] = mk(0, 4'b0011, 0, 1, 2'd1, 4'b0010, 1, 0);
    tv[24] = mk(0, 4'b0000, 0, 1, 2'd1, 4'b0000, 0, 0);
`else
    tv[20] = mk(0, 4'b0011, 1, 1, 2'd1, 4'b0010, 1, 0);
    tv[21] = mk(0, 4'b0011, 1, 1, 2'd0, 4'b0001, 1, 0);
    tv[22] = mk(0, 4'b0011, 1, 1, 2'd1, 4'b0010, 1, 0);
    tv[23] = mk(0, 4'b0011, 0, 1, 2'd0, 4'b0001, 1, 0);
    tv[24] = mk(0, 4'b0000, 0, 1, 2'd0, 4'b0000, 0, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      step(tv[i].rst, tv[i].req, tv[i].lock, tv[i].ready);
      check($sformatf("vec%0d", i), tv[i].e_sel, tv[i].e_grant, tv[i].e_valid, tv[i].e_tmo);
    end

    // stalled grant: abandoned on the TIMEOUT-th BUSY edge without ready
    step(0, 4'b0100, 0, 0);
    check("tmo_grant", 2'd2, 4'b0100, 1, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      step(0, 4'b0100, 0, 0);
      check($sformatf("tmo_hold%0d", k), 2'd2, 4'b0100, 1, 0);
    end
    step(0, 4'b0100, 0, 0);
    check("tmo_pulse", 2'd2, 4'b0000, 0, 1);
    // stalled source lost priority: last=2, so 4'b0110 grants 1
    step(0, 4'b0110, 0, 0);
    check("tmo_after", 2'd1, 4'b0010, 1, 0);
    step(0, 4'b0000, 0, 1);
    check("tmo_drain", 2'd1, 4'b0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
